// File: rtl/result_bcd_pkg.sv
// Shared types and constants for the result binary-to-BCD converter.
package result_bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DIGITS = 5;

  localparam logic [3:0] ADD3_THRESH = 4'd5;

  localparam int CNT_W = $clog2(DEF_WIDTH + 1);

  // Counter width for a non-default WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/result_bcd_converter_bcd_digit_adjust.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more.
// Latency: combinational. Backpressure: none.
// Flow control: not applicable.
module bcd_digit_adjust
  import result_bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= ADD3_THRESH) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/result_bcd_converter.sv
// Iterative binary-to-BCD converter for the CPU result display; RESULT_BCD_SIGNED_EN selects two's complement input.
// Latency: WIDTH cycles from accepting start to bcd/neg update, done pulses the cycle after.
// Backpressure: start is ignored while busy, nothing is queued.
module result_bcd_converter
  import result_bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t state, next_state;

  logic [WIDTH-1:0]          opnd;
  logic [4*DIGITS-1:0]       scratch;
  logic [4*DIGITS-1:0]       adjusted;
  logic [4*DIGITS+WIDTH-1:0] shift_word;
  logic [CW-1:0]             cnt;
  logic [WIDTH-1:0]          magnitude;
  logic                      accept;
  logic                      last_shift;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (scratch[4*d +: 4]),
      .digit_out (adjusted[4*d +: 4])
    );
  end

  // The top scratch bit falls off here; DIGITS is sized so it is always zero.
  assign shift_word = {adjusted, opnd} << 1;

`ifdef RESULT_BCD_SIGNED_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic neg_pend;

  assign magnitude = value[WIDTH-1] ? (~value + ONE) : value;
`else
  assign magnitude = value;
  assign neg       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_shift = 1'b0;
    busy       = (state == SHIFT);
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_CNT) begin
          last_shift = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd    <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      done    <= 1'b0;
    end else begin
      done <= last_shift;
      if (accept) begin
        opnd    <= magnitude;
        scratch <= '0;
        cnt     <= '0;
      end else if (busy) begin
        opnd    <= shift_word[WIDTH-1:0];
        scratch <= shift_word[4*DIGITS+WIDTH-1:WIDTH];
        cnt     <= cnt + CW'(1);
        if (last_shift) bcd <= shift_word[4*DIGITS+WIDTH-1:WIDTH];
      end
    end
  end

`ifdef RESULT_BCD_SIGNED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_pend <= 1'b0;
      neg      <= 1'b0;
    end else begin
      if (accept)     neg_pend <= value[WIDTH-1];
      if (last_shift) neg      <= neg_pend;
    end
  end
`endif

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed bench for result_bcd_converter; expectations follow RESULT_BCD_SIGNED_EN.
module tb_result_bcd_converter;

  localparam int W = 16;
  localparam int D = 5;

`ifdef RESULT_BCD_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   value;
  logic           busy;
  logic           done;
  logic           neg;
  logic [4*D-1:0] bcd;

  int total = 0;
  int bad   = 0;

  result_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .neg   (neg),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a conversion from the current cycle and leaves the bench in the done cycle.
  task automatic convert(input logic [W-1:0] v, input logic [4*D-1:0] exp_bcd,
                         input logic exp_neg, input string name,
                         input logic [4*D-1:0] hold_bcd, input logic hold_neg);
    int busy_bad;
    int hold_bad;
    busy_bad = 0;
    hold_bad = 0;
    value = v;
    start = 1'b1;
    step();
    start = 1'b0;
    value = 16'hA5C3;
    for (int i = 0; i < W; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
      if (bcd !== hold_bcd || neg !== hold_neg) hold_bad++;
      step();
    end
    total++;
    if (busy_bad != 0) begin
      bad++;
      $display("FAIL %s busy_window: %0d of %0d cycles wrong, required 0", name, busy_bad, W);
    end
    total++;
    if (hold_bad != 0) begin
      bad++;
      $display("FAIL %s hold: %0d cycles bcd/neg moved early, required 0", name, hold_bad);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s done_cycle: done=%b busy=%b required done=1 busy=0", name, done, busy);
    end
    total++;
    if (bcd !== exp_bcd || neg !== exp_neg) begin
      bad++;
      $display("FAIL %s result: bcd=%h neg=%b required bcd=%h neg=%b", name, bcd, neg, exp_bcd, exp_neg);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    #12;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || neg !== 1'b0 || bcd !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b neg=%b bcd=%h required all 0", busy, done, neg, bcd);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    convert(16'h3039, 20'h12345, 1'b0, "basic_12345", 20'h00000, 1'b0);
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_width: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_patterns();
    logic [4*D-1:0] pb;
    logic           pn;
    convert(16'hFE0C, SIGNED_BUILD ? 20'h00500 : 20'h65036, SIGNED_BUILD,
            "fe0c", 20'h12345, 1'b0);
    pb = SIGNED_BUILD ? 20'h00500 : 20'h65036;
    pn = SIGNED_BUILD;
    step();
    convert(16'h8000, 20'h32768, SIGNED_BUILD, "min_8000", pb, pn);
    step();
    convert(16'hFFFF, SIGNED_BUILD ? 20'h00001 : 20'h65535, SIGNED_BUILD,
            "ffff", 20'h32768, SIGNED_BUILD);
    pb = SIGNED_BUILD ? 20'h00001 : 20'h65535;
    step();
    convert(16'h0000, 20'h00000, 1'b0, "zero", pb, SIGNED_BUILD);
    step();
  endtask

  task automatic test_ignore_start();
    int cyc;
    value = 16'h3039;
    start = 1'b1;
    step();
    start = 1'b0;
    value = '0;
    cyc = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      cyc++;
    end
    value = 16'd9;
    start = 1'b1;
    step();
    cyc++;
    start = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    total++;
    if (cyc != W + 1) begin
      bad++;
      $display("FAIL ignore_latency: done seen in cycle %0d required %0d", cyc, W + 1);
    end
    total++;
    if (bcd !== 20'h12345 || neg !== 1'b0) begin
      bad++;
      $display("FAIL ignore_result: bcd=%h neg=%b required bcd=12345 neg=0", bcd, neg);
    end
    step();
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_no_queue: busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    convert(16'h3039, 20'h12345, 1'b0, "b2b_first", 20'h12345, 1'b0);
    convert(16'd9, 20'h00009, 1'b0, "b2b_second", 20'h12345, 1'b0);
    step();
  endtask

  task automatic test_hold();
    convert(16'd1, 20'h00001, 1'b0, "hold_prime", 20'h00009, 1'b0);
    step();
    convert(16'h3039, 20'h12345, 1'b0, "hold_3039", 20'h00001, 1'b0);
    step();
  endtask

  task automatic test_reset_mid();
    int done_seen;
    value = 16'hFFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre_busy: busy=%b required 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || neg !== 1'b0 || bcd !== '0) begin
      bad++;
      $display("FAIL midrst_async: busy=%b done=%b neg=%b bcd=%h required all 0", busy, done, neg, bcd);
    end
    step();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < W + 6; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
      step();
    end
    total++;
    if (done_seen != 0 || bcd !== '0) begin
      bad++;
      $display("FAIL midrst_after: %0d active cycles, bcd=%h required 0 cycles bcd=00000", done_seen, bcd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_ignore_start();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
